prueba_nco: RTL and testbench
=============================

# prueba_nco

Numerically controlled oscillator that turns a 32-bit per-sample phase increment into a signed 14-bit sine sample stream. It is the DAC stimulus source of the impedance-measurement control path. The control path loads a new tuning word from its frequency ROM, waits for `out_valid`, and then times zero crossings on the sine's sign bit. Everything is on the single 125 MHz sample clock.

## Interface
- `PHASE_WIDTH`, default 32: accumulator and tuning-word width.
- `OUT_WIDTH`, default 14: signed sample width.
- `LUT_ADDR_WIDTH`, default 10: quarter-wave table address width (2^10 entries).
- `clk`, input, 1: sample clock; all logic on its rising edge.
- `rst`, input, 1: reset. Synchronous, active-high.
- `clken`, input, 1: clock enable. When 0, every register holds.
- `phi_inc_i`, input, PHASE_WIDTH: unsigned phase increment per enabled cycle. Output frequency is f_clk·phi_inc_i/2^32.
- `fsin_o`, output, OUT_WIDTH: signed two's-complement sine sample, registered.
- `out_valid`, output, 1: high once the pipeline holds real samples.

## Operation
- Accumulator `acc` (PHASE_WIDTH bits) updates on every enabled edge: `acc <= acc + phi_inc_i`, modulo 2^PHASE_WIDTH. Wrap-around is silent.
- `phi_inc_i` is sampled every enabled edge. A change takes effect on the next enabled edge. Output stays phase-continuous; there is no reset of `acc` on retune.
- Phase decode of the accumulator value:
  - quadrant `q` = top 2 bits.
  - `a` = next LUT_ADDR_WIDTH bits; lower bits are truncated, no dither.
- Table address: `a` when q is 0 or 2, `~a` (bitwise mirror) when q is 1 or 3.
- Quarter-wave ROM, N = 2^LUT_ADDR_WIDTH entries, A = 2^(OUT_WIDTH-1)-1 = 8191:
  - entry k = round(A·sin(π/2·(k+0.5)/N)).
  - Entries are all strictly positive. Entry 0 = 6, entry N-1 = 8191.
  - Half-LSB phase offset makes the bitwise mirror exact.
- Output sign: positive for q = 0 or 1, two's-complement negated for q = 2 or 3.
  - Consequences: `fsin_o` is never 0 after valid; `fsin_o[OUT_WIDTH-1]` equals the delayed `q[1]`; the range is exactly ±8191.
- ROM contents come from a constant function or an initial-block computation at elaboration. No external file.
- `out_valid` is driven by a saturating counter of enabled edges since reset, 0..4. `out_valid` = 1 when the count is 4. Once high it stays high until `rst`.

## Timing
- Pipeline of 4 enabled stages:
  1. Stage 1 registers the pre-update `acc`.
  2. Stage 2 registers q and the mirrored address.
  3. Stage 3 is the registered ROM read plus delayed q[1].
  4. Stage 4 applies the sign and registers `fsin_o`.
- With a constant increment `inc`, after the n-th enabled edge following reset (n ≥ 4), `fsin_o` = S((n-4)·inc mod 2^32). S is the decode described above.
- `out_valid` rises coincident with the first valid sample, after the 4th enabled edge.
- Reset values, applied on any `rst`-high edge including mid-stream: `acc` = 0, all pipeline registers = 0, `fsin_o` = 0, `out_valid` = 0, valid counter = 0.
  - `rst` has priority over `clken`.
  - After release, behaviour is identical to power-up.
- `clken` low: `acc`, pipeline, `fsin_o`, `out_valid` and counter all hold. Disabled edges do not count toward latency.

## Configuration
- `PRUEBA_NCO_COS_EN` defined: adds output port `fcos_o` (OUT_WIDTH, signed, reset 0).
  - Produced by the same decode applied to phase + 2^(PHASE_WIDTH-2), i.e. q+1.
  - Uses a second ROM read port or a duplicated ROM.
  - Same 4-cycle latency and same `out_valid`.
- Macro undefined: `fcos_o` port and its logic are absent. Sine behaviour is unchanged.

## Test plan
- Quarter rate: reset, `phi_inc_i` = 0x40000000, `clken` = 1 → `out_valid` rises after the 4th edge; `fsin_o` repeats 6, 8191, -6, -8191. With `PRUEBA_NCO_COS_EN`, `fcos_o` repeats 8191, -6, -8191, 6.
- DC and reverse wrap: `phi_inc_i` = 0 → `fsin_o` constant 6. `phi_inc_i` = 0xFFFFFFFF → first samples 6, -6, -6, …
- 128-sample period: `phi_inc_i` = 0x02000000 → sign bit high for exactly 64 consecutive samples each period; max 8191, min -8191, no zero samples.
- Clock enable: drop `clken` for 5 cycles mid-stream → `fsin_o` and `out_valid` frozen. Sequence resumes with no skipped or repeated sample.
- Reset mid-stream: assert `rst` for 1 cycle while valid → `fsin_o` = 0 and `out_valid` = 0 after that edge; `out_valid` returns exactly 4 enabled edges later with sample S(0) = 6.
- Retune: switch `phi_inc_i` from 0x02000000 to 0x04000000 at sample 10 → phase is continuous; the increment change appears at the output 4 enabled edges later.

Source files
------------

// File: rtl/prueba_nco.sv
// rtl/prueba_nco.sv - 4-stage quarter-wave LUT sine NCO on a single sample clock.
// Optional cosine output port fcos_o is compiled in when PRUEBA_NCO_COS_EN is defined.
module prueba_nco #(
    parameter int PHASE_WIDTH    = 32,
    parameter int OUT_WIDTH      = 14,
    parameter int LUT_ADDR_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clken,
    input  logic [PHASE_WIDTH-1:0] phi_inc_i,
    output logic [OUT_WIDTH-1:0]   fsin_o,
`ifdef PRUEBA_NCO_COS_EN
    output logic [OUT_WIDTH-1:0]   fcos_o,
`endif
    output logic                   out_valid
);

    localparam int DEC_W     = LUT_ADDR_WIDTH + 2;
    localparam int ROM_DEPTH = 1 << LUT_ADDR_WIDTH;
    localparam int MAG_W     = OUT_WIDTH - 1;

    localparam logic signed [127:0] HALF_PI_Q60 = 128'sh1921FB54442D1846;
    localparam logic signed [127:0] AMP_Q       = 128'((1 << (OUT_WIDTH - 1)) - 1);

    // Q60 fixed-point Taylor series; precise enough that rounding never lands on a tie.
    function automatic logic [MAG_W-1:0] rom_entry(input int k);
        logic signed [127:0] x;
        logic signed [127:0] x2;
        logic signed [127:0] term;
        logic signed [127:0] sum;
        logic signed [127:0] div;
        logic signed [127:0] prod;
        x    = (128'(2 * k + 1) * HALF_PI_Q60) >>> (LUT_ADDR_WIDTH + 1);
        x2   = (x * x) >>> 60;
        term = x;
        sum  = x;
        for (int i = 1; i <= 10; i++) begin
            div  = 128'((2 * i) * (2 * i + 1));
            term = -(((term * x2) >>> 60) / div);
            sum  = sum + term;
        end
        prod = sum * AMP_Q + (128'sd1 <<< 59);
        return MAG_W'(prod >>> 60);
    endfunction

    logic [MAG_W-1:0] rom [ROM_DEPTH];

    for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
        localparam logic [MAG_W-1:0] ENTRY = rom_entry(k);
        assign rom[k] = ENTRY;
    end

    logic [PHASE_WIDTH-1:0]    acc;
    logic [DEC_W-1:0]          ph1;
    logic [1:0]                q2;
    logic [LUT_ADDR_WIDTH-1:0] addr2;
    logic [MAG_W-1:0]          mag3;
    logic                      neg3;
    logic [2:0]                vcnt;

    logic [1:0]                q1;
    logic [LUT_ADDR_WIDTH-1:0] a1;

    assign q1 = ph1[DEC_W-1 -: 2];
    assign a1 = ph1[LUT_ADDR_WIDTH-1:0];

    // Only the phase bits that reach the decoder are kept in stage 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            ph1    <= '0;
            q2     <= '0;
            addr2  <= '0;
            mag3   <= '0;
            neg3   <= 1'b0;
            fsin_o <= '0;
            vcnt   <= '0;
        end else if (clken) begin
            acc    <= acc + phi_inc_i;
            ph1    <= acc[PHASE_WIDTH-1 -: DEC_W];
            q2     <= q1;
            addr2  <= q1[0] ? ~a1 : a1;
            mag3   <= rom[addr2];
            neg3   <= q2[1];
            fsin_o <= neg3 ? -{1'b0, mag3} : {1'b0, mag3};
            if (vcnt != 3'd4) begin
                vcnt <= vcnt + 3'd1;
            end
        end
    end

    assign out_valid = (vcnt == 3'd4);

`ifdef PRUEBA_NCO_COS_EN
    logic [LUT_ADDR_WIDTH-1:0] addrc2;
    logic [MAG_W-1:0]          magc3;
    logic                      negc3;
    logic [1:0]                qc1;
    logic [1:0]                qc2;

    // Cosine is the same decode a quarter turn ahead.
    assign qc1 = q1 + 2'd1;
    assign qc2 = q2 + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            addrc2 <= '0;
            magc3  <= '0;
            negc3  <= 1'b0;
            fcos_o <= '0;
        end else if (clken) begin
            addrc2 <= qc1[0] ? ~a1 : a1;
            magc3  <= rom[addrc2];
            negc3  <= qc2[1];
            fcos_o <= negc3 ? -{1'b0, magc3} : {1'b0, magc3};
        end
    end
`endif

endmodule

// File: tb/tb_prueba_nco.sv
// tb/tb_prueba_nco.sv - self-checking bench for prueba_nco against a real-valued sine model.
module tb_prueba_nco;

    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clken = 1'b0;
    logic [31:0] phi_inc_i = '0;
    logic [13:0] fsin_o;
`ifdef PRUEBA_NCO_COS_EN
    logic [13:0] fcos_o;
`endif
    logic        out_valid;

    always #4 clk = ~clk;

    prueba_nco dut (
        .clk       (clk),
        .rst       (rst),
        .clken     (clken),
        .phi_inc_i (phi_inc_i),
        .fsin_o    (fsin_o),
`ifdef PRUEBA_NCO_COS_EN
        .fcos_o    (fcos_o),
`endif
        .out_valid (out_valid)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mphase = '0;
    logic [31:0] phq[$];
    int          exp_fsin = 0;
    int          exp_fcos = 0;
    logic        exp_valid = 1'b0;

    typedef struct {
        logic [31:0] inc;
        int          edges;
        int          exp;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Sine of the 12-bit quantised phase, sampled mid-bin.
    function automatic int ref_sin(input logic [31:0] ph);
        int  p;
        real v;
        p = int'(ph[31:20]);
        v = 8191.0 * $sin(2.0 * PI * (real'(p) + 0.5) / 4096.0);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    task automatic step(input logic [31:0] inc, input logic en, input logic r);
        logic [31:0] ph;
        phi_inc_i = inc;
        clken     = en;
        rst       = r;
        @(posedge clk);
        if (r) begin
            phq.delete();
            mphase    = '0;
            exp_fsin  = 0;
            exp_fcos  = 0;
            exp_valid = 1'b0;
        end else if (en) begin
            phq.push_back(mphase);
            mphase = mphase + inc;
            if (phq.size() == 4) begin
                ph        = phq.pop_front();
                exp_fsin  = ref_sin(ph);
                exp_fcos  = ref_sin(ph + 32'h4000_0000);
                exp_valid = 1'b1;
            end
        end
        #1;
        chk("model_valid", int'(out_valid), int'(exp_valid));
        if (exp_valid || r) begin
            chk("model_fsin", int'($signed(fsin_o)), exp_fsin);
`ifdef PRUEBA_NCO_COS_EN
            chk("model_fcos", int'($signed(fcos_o)), exp_fcos);
`endif
        end
    endtask

    task automatic run(input logic [31:0] inc, input int n);
        repeat (n) step(inc, 1'b1, 1'b0);
    endtask

    initial begin
        int          s;
        int          run_len;
        int          runs;
        int          mx;
        int          mn;
        int          zeros;
        logic [31:0] inc;
        logic        en;
        logic        r;

        vecs.push_back('{32'h4000_0000, 4, 6});
        vecs.push_back('{32'h4000_0000, 5, 8191});
        vecs.push_back('{32'h4000_0000, 6, -6});
        vecs.push_back('{32'h4000_0000, 7, -8191});
        vecs.push_back('{32'h4000_0000, 8, 6});
        vecs.push_back('{32'h0000_0000, 4, 6});
        vecs.push_back('{32'h0000_0000, 12, 6});
        vecs.push_back('{32'hFFFF_FFFF, 4, 6});
        vecs.push_back('{32'hFFFF_FFFF, 5, -6});
        vecs.push_back('{32'hFFFF_FFFF, 6, -6});
        vecs.push_back('{32'h0200_0000, 36, 8191});
        vecs.push_back('{32'h0200_0000, 68, -6});
        vecs.push_back('{32'h0200_0000, 100, -8191});

        step(32'h0, 1'b1, 1'b1);
        chk("reset_fsin", int'($signed(fsin_o)), 0);
        chk("reset_valid", int'(out_valid), 0);

        step(32'h4000_0000, 1'b1, 1'b1);
        run(32'h4000_0000, 3);
        chk("valid_before_4th", int'(out_valid), 0);
        run(32'h4000_0000, 1);
        chk("valid_at_4th", int'(out_valid), 1);

        foreach (vecs[i]) begin
            step(vecs[i].inc, 1'b1, 1'b1);
            run(vecs[i].inc, vecs[i].edges);
            chk($sformatf("vec%0d_fsin", i), int'($signed(fsin_o)), vecs[i].exp);
        end

        // 128-sample period: sign-bit run lengths and amplitude extremes.
        step(32'h0200_0000, 1'b1, 1'b1);
        run(32'h0200_0000, 3);
        run_len = 0; runs = 0; mx = -100000; mn = 100000; zeros = 0;
        for (int i = 0; i < 300; i++) begin
            step(32'h0200_0000, 1'b1, 1'b0);
            s = int'($signed(fsin_o));
            if (s > mx) mx = s;
            if (s < mn) mn = s;
            if (s == 0) zeros++;
            if (fsin_o[13]) begin
                run_len++;
            end else begin
                if (run_len > 0) begin
                    chk("sign_run_len", run_len, 64);
                    runs++;
                end
                run_len = 0;
            end
        end
        chk("sign_runs", runs, 2);
        chk("period_max", mx, 8191);
        chk("period_min", mn, -8191);
        chk("period_zeros", zeros, 0);

        repeat (5) step(32'h0200_0000, 1'b0, 1'b0);
        run(32'h0200_0000, 10);

        step(32'h0200_0000, 1'b1, 1'b1);
        chk("midrst_fsin", int'($signed(fsin_o)), 0);
        chk("midrst_valid", int'(out_valid), 0);
        run(32'h0200_0000, 2);
        repeat (2) step(32'h0200_0000, 1'b0, 1'b0);
        run(32'h0200_0000, 1);
        chk("midrst_valid_3edges", int'(out_valid), 0);
        run(32'h0200_0000, 1);
        chk("midrst_valid_4edges", int'(out_valid), 1);
        chk("midrst_first_sample", int'($signed(fsin_o)), 6);

        step(32'h0200_0000, 1'b1, 1'b1);
        run(32'h0200_0000, 14);
        run(32'h0400_0000, 3);
        run(32'h0400_0000, 1);
        chk("retune_last_old", int'($signed(fsin_o)), ref_sin(32'd14 << 25));
        run(32'h0400_0000, 1);
        chk("retune_first_new", int'($signed(fsin_o)), ref_sin(32'd16 << 25));
        run(32'h0400_0000, 30);

        inc = $urandom;
        step(inc, 1'b1, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                inc = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom >> $urandom_range(4, 28));
            end
            en = ($urandom_range(0, 99) < 85);
            r  = ($urandom_range(0, 199) == 0);
            step(inc, en, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
